// File: rtl/dht_poll_scheduler.sv
// dht_poll_scheduler: paces DHT11 reads, validates frames, publishes last-good readings and fan control
module dht_poll_scheduler #(
  parameter int INTERVAL_CYC = 200_000_000,
  parameter int TIMEOUT_CYC  = 5_000_000,
  parameter int MAX_RETRY    = 3,
  parameter int FAN_ON_C     = 30,
  parameter int FAN_OFF_C    = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        force_read,
  output logic        rd_start,
  input  logic        rd_busy,
  input  logic        rd_done,
  input  logic [39:0] rd_frame,
  output logic [7:0]  temp_int,
  output logic [7:0]  hum_int,
  output logic        valid,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic        fan
);
  localparam int IW = $clog2(INTERVAL_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  typedef enum logic [2:0] {IDLE, HOLDOFF, ISSUE, WAIT_DONE, CHECK} state_t;
  state_t state;
  logic [IW-1:0] ivl;
  logic [TW-1:0] tmo;
  logic [RW-1:0] retry;
  logic [39:0] frame;
  logic [7:0] csum;
  logic force_pending, want, ivl_due, good, fail;
  assign rd_start = state == ISSUE && !rd_busy;
  assign want = en || force_pending;
  assign ivl_due = ivl >= IW'(INTERVAL_CYC - 1);
  assign csum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
  assign good = state == CHECK && csum == frame[7:0];
  assign fail = (state == CHECK && csum != frame[7:0]) ||
                (state == WAIT_DONE && !rd_done && tmo == TW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ivl <= '0;
      tmo <= '0;
      retry <= '0;
      frame <= '0;
      force_pending <= 1'b0;
      temp_int <= '0;
      hum_int <= '0;
      valid <= 1'b0;
      err <= 1'b0;
      err_cnt <= '0;
      fan <= 1'b0;
    end else begin
      ivl <= rd_start ? IW'(1) : (ivl == IW'(INTERVAL_CYC) ? ivl : ivl + IW'(1));
      tmo <= state == WAIT_DONE ? tmo + TW'(1) : '0;
      force_pending <= force_read || (force_pending && !rd_start);
      if (state == WAIT_DONE && rd_done) frame <= rd_frame;
      case (state)
        IDLE:      if (want) state <= HOLDOFF;
        HOLDOFF:   state <= !want ? IDLE : (ivl_due ? ISSUE : HOLDOFF);
        ISSUE:     if (!rd_busy) state <= WAIT_DONE;
        WAIT_DONE: state <= rd_done ? CHECK : (fail ? HOLDOFF : WAIT_DONE);
        CHECK:     state <= HOLDOFF;
        default:   state <= IDLE;
      endcase
      if (good) begin
        temp_int <= frame[23:16];
        hum_int <= frame[39:32];
        valid <= 1'b1;
        retry <= '0;
        err <= 1'b0;
        fan <= frame[23:16] >= 8'(FAN_ON_C) ? 1'b1 : (frame[23:16] <= 8'(FAN_OFF_C) ? 1'b0 : fan);
      end
      if (fail) begin
        err_cnt <= err_cnt + {7'd0, err_cnt != 8'hFF};
        retry <= retry + RW'(retry != RW'(MAX_RETRY));
        if (retry >= RW'(MAX_RETRY - 1)) begin
          err <= 1'b1;
          fan <= 1'b1;
        end
      end
    end
  end
endmodule
